// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imm_decode_stage_if : handshake/payload bundle for imm_decode_stage |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface imm_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [31:0]     instruction_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] Immediate_o;
   logic [2:0]      fmt_o;
   logic            unknown_o;
   logic [31:0]     instr_o;

   modport slave (
      input  valid_i, instruction_i, ready_i,
      output ready_o, valid_o, Immediate_o, fmt_o, unknown_o, instr_o
   );

   modport master (
      output valid_i, instruction_i, ready_i,
      input  ready_o, valid_o, Immediate_o, fmt_o, unknown_o, instr_o
   );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imm_decode_stage : RV32I immediate decode with two-entry skid stage |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module imm_decode_stage #(
   parameter int XLEN       = 32,
   parameter bit PASS_INSTR = 1'b1
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   input  wire logic          flush_i,
   imm_decode_stage_if.slave  bus
);
   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   logic [31:0]     ins;
   logic [63:0]     imm64;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_unk;

   assign ins = bus.instruction_i;

   // Build every immediate at 64 bits, then truncate to XLEN.
   always_comb begin
      imm64   = 64'd0;
      dec_fmt = FMT_NONE;
      dec_unk = 1'b0;
      case (ins[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec_fmt = FMT_I;
            imm64   = {{52{ins[31]}}, ins[31:20]};
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            imm64   = {{52{ins[31]}}, ins[31:25], ins[11:7]};
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            imm64   = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            imm64   = {{32{ins[31]}}, ins[31:12], 12'h000};
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            imm64   = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         7'b1110011: begin
            if (ins[14]) begin
               dec_fmt = FMT_Z;
               imm64   = {59'd0, ins[19:15]};
            end
         end
         7'b0110011, 7'b0001111: dec_fmt = FMT_NONE;
         default:                dec_unk = 1'b1;
      endcase
   end

   assign dec_imm = imm64[XLEN-1:0];

   logic            main_valid_q, main_valid_d;
   logic [XLEN-1:0] main_imm_q,   main_imm_d;
   logic [2:0]      main_fmt_q,   main_fmt_d;
   logic            main_unk_q,   main_unk_d;
   logic [31:0]     main_instr_q, main_instr_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
   logic [2:0]      skid_fmt_q,   skid_fmt_d;
   logic            skid_unk_q,   skid_unk_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic            ready_q,      ready_d;
   logic            accept;
   logic            drain;

   assign accept = bus.valid_i & ready_q;
   assign drain  = main_valid_q & bus.ready_i;

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_fmt_d   = main_fmt_q;
      main_unk_d   = main_unk_q;
      main_instr_d = main_instr_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;
      skid_unk_d   = skid_unk_q;
      skid_instr_d = skid_instr_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q && drain) begin
         // ready_q is low whenever skid is full, so no accept competes here.
         main_valid_d = 1'b1;
         main_imm_d   = skid_imm_q;
         main_fmt_d   = skid_fmt_q;
         main_unk_d   = skid_unk_q;
         main_instr_d = skid_instr_q;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || drain) begin
         main_valid_d = accept;
         if (accept) begin
            main_imm_d   = dec_imm;
            main_fmt_d   = dec_fmt;
            main_unk_d   = dec_unk;
            main_instr_d = ins;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_fmt_d   = dec_fmt;
         skid_unk_d   = dec_unk;
         skid_instr_d = ins;
      end
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_fmt_q   <= FMT_NONE;
         main_unk_q   <= 1'b0;
         main_instr_q <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_fmt_q   <= FMT_NONE;
         skid_unk_q   <= 1'b0;
         skid_instr_q <= 32'd0;
         ready_q      <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_fmt_q   <= main_fmt_d;
         main_unk_q   <= main_unk_d;
         main_instr_q <= main_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_fmt_q   <= skid_fmt_d;
         skid_unk_q   <= skid_unk_d;
         skid_instr_q <= skid_instr_d;
         ready_q      <= ready_d;
      end
   end

   assign bus.valid_o     = main_valid_q;
   assign bus.ready_o     = ready_q;
   assign bus.Immediate_o = main_imm_q;
   assign bus.fmt_o       = main_fmt_q;
   assign bus.unknown_o   = main_unk_q;

   generate
      if (PASS_INSTR) begin : g_pass_instr
         assign bus.instr_o = main_instr_q;
      end else begin : g_tie_instr
         assign bus.instr_o = 32'd0;
      end
   endgenerate
endmodule
`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-generation pipeline stage for the decode path. It accepts one instruction per cycle over a valid/ready handshake and classifies its RV32I encoding format. It produces the sign- or zero-extended immediate at XLEN width, together with a format code and an unknown-opcode flag. A two-entry skid buffer makes `ready_o` a pure register output, and a synchronous flush drops in-flight entries on redirect.

## Interface

Reset is asynchronous and active-high. The block has one clock.

Parameters:
- `XLEN`, default 32: immediate and datapath width. Legal values are 32 and 64.
- `PASS_INSTR`, default 1: when 1, `instr_o` carries the accepted instruction. When 0, `instr_o` is tied to 0.

Ports:
- `clk_i`, input, 1: clock. All state updates on the rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `flush_i`, input, 1: synchronous flush. Clears all stored entries.
- `valid_i`, input, 1: `instruction_i` is valid this cycle.
- `ready_o`, output, 1: stage can accept this cycle. Registered.
- `instruction_i`, input, 32: raw instruction word.
- `valid_o`, output, 1: output entry valid.
- `ready_i`, input, 1: downstream accepts the output entry this cycle.
- `Immediate_o`, output, XLEN: decoded immediate.
- `fmt_o`, output, 3: format code. 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm).
- `unknown_o`, output, 1: opcode is not a recognised RV32I opcode.
- `instr_o`, output, 32: instruction that belongs to the output entry.

## Operation

Decode is combinational on `instruction_i` and is captured when the instruction is accepted. `op` = `instruction_i[6:0]`; `sx` = sign-extend to XLEN from `instruction_i[31]`.
- I format: op is 0010011, 0000011 or 1100111. imm = sx(`[31:20]`).
- S format: op is 0100011. imm = sx({`[31:25]`, `[11:7]`}).
- B format: op is 1100011. imm = sx({`[31]`, `[7]`, `[30:25]`, `[11:8]`, 1'b0}).
- U format: op is 0110111 or 0010111. imm = sx({`[31:12]`, 12'h000}). At XLEN=64, bit 31 fills bits 63:32.
- J format: op is 1101111. imm = sx({`[31]`, `[19:12]`, `[20]`, `[30:21]`, 1'b0}).
- Z format: op is 1110011 and `[14]`=1. imm = zero-extend(`[19:15]`).
- NONE with `unknown_o`=0: op is 0110011, 0001111, or 1110011 with `[14]`=0. imm = 0.
- Any other op: fmt = NONE, imm = 0, `unknown_o`=1.

Storage:
- The stage holds two entries: main (drives the outputs) and skid.
- Each entry stores {imm, fmt, unknown, instr}.
- Accept: `valid_i & ready_o`.
- Drain: `valid_o & ready_i`.

Register update, evaluated in priority order:
1. `flush_i`: main and skid valid bits both cleared. Any input presented that cycle is dropped.
2. Skid valid and drain: main ← skid, skid invalid.
3. Main empty, or drain: main ← accepted input, or invalid if nothing is accepted.
4. Main valid, no drain, and accept: skid ← accepted input.

`ready_o` (next) = NOT skid valid (next).

Order is strictly FIFO, so skid is always older than any new input. No entry is ever dropped or duplicated except by flush or reset.

## Timing

- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N with `valid_o`=1.
- Throughput is 1 per cycle when `ready_i` is held high. The skid buffer is never used in that case.
- With `ready_i` low and main valid:
  - One further input is absorbed into skid.
  - `ready_o` falls in the cycle after that capture.
- When `ready_i` returns high:
  - Skid moves to main on the next edge.
  - `ready_o` rises on the same edge.
- Output payload (`Immediate_o`, `fmt_o`, `unknown_o`, `instr_o`) holds stable while `valid_o`=1 and `ready_i`=0.
- Payload is don't-care when `valid_o`=0, but it must not contain X after reset.
- Reset values:
  - `valid_o`=0
  - `ready_o`=1
  - `Immediate_o`=0
  - `fmt_o`=0
  - `unknown_o`=0
  - `instr_o`=0
  - internal skid valid = 0
- Reset asserted mid-stream discards both entries immediately (asynchronous reset). The first accept after deassertion is legal on the first rising edge.
- Flush takes effect at the edge. `valid_o`=0 and `ready_o`=1 in the following cycle, regardless of `ready_i`.

## Test plan

- Reset then single beats with `ready_i`=1 and XLEN=32:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 → imm 0xFFFFFFF8, fmt 3.
  - 0x001000EF → imm 0x00000800, fmt 5.
  - Each appears one cycle after accept.
- U/Z/unknown cases:
  - 0x123452B7 → imm 0x12345000, fmt 4.
  - 0x0007D073 (csrrwi, zimm 15) → imm 0x0000000F, fmt 6.
  - 0x00000033 → imm 0, fmt 0, `unknown_o`=0.
  - 0x0000007F → `unknown_o`=1.
- XLEN=64: 0x800002B7 → imm 0xFFFFFFFF80000000; 0x7FF00093 → imm 0x00000000000007FF.
- Backpressure:
  - Setup: `ready_i`=0, stream A, B, C back to back.
  - A is held on the outputs and B goes to skid.
  - `ready_o` is 0 in the cycle after B is accepted, so C is not accepted.
  - Raise `ready_i`: outputs are A, then B, then C, in order, with no loss or duplication.
- Flush: with main and skid both full and `valid_i`=1, pulse `flush_i`. Next cycle `valid_o`=0 and `ready_o`=1, and the presented instruction never appears.
- Asynchronous reset mid-stream: assert `rst_i` between clock edges with both entries full. Outputs go to reset values immediately, without waiting for a clock edge.
